// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request front end.
// Holds direction/floor encodings, button indices, debounce states and the serve mask.
// Pure declarations plus one combinational helper; no state.
package elevator_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  localparam logic [1:0] FLOOR_NONE = 2'd0;
  localparam logic [1:0] FLOOR_1    = 2'd1;
  localparam logic [1:0] FLOOR_2    = 2'd2;
  localparam logic [1:0] FLOOR_3    = 2'd3;

  localparam int NUM_BTNS = 7;

  typedef enum logic [2:0] {
    BTN_F3 = 3'd0,
    BTN_F2 = 3'd1,
    BTN_F1 = 3'd2,
    BTN_D3 = 3'd3,
    BTN_D2 = 3'd4,
    BTN_U2 = 3'd5,
    BTN_U1 = 3'd6
  } btn_idx_t;

  typedef enum logic [1:0] {
    DB_RELEASED = 2'd0,
    DB_COUNTING = 2'd1,
    DB_HELD     = 2'd2
  } db_state_t;

  // Which request flags the car is serving right now. Nothing is served while the
  // door is shut or the car is between floors. The reserved direction code 2'b11
  // behaves like idle, so a floor-2 hall call only survives when the car is
  // explicitly heading the other way.
  function automatic logic [NUM_BTNS-1:0] serve_mask(input logic [1:0] fs,
                                                     input logic       door_open,
                                                     input logic [1:0] dir);
    logic [NUM_BTNS-1:0] m;
    m = '0;
    if (door_open && (fs != FLOOR_NONE)) begin
      m[BTN_F1] = (fs == FLOOR_1);
      m[BTN_F2] = (fs == FLOOR_2);
      m[BTN_F3] = (fs == FLOOR_3);
      m[BTN_U1] = (fs == FLOOR_1);
      m[BTN_D3] = (fs == FLOOR_3);
      m[BTN_U2] = (fs == FLOOR_2) && (dir != DIR_DOWN);
      m[BTN_D2] = (fs == FLOOR_2) && (dir != DIR_UP);
    end
    return m;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Debounces one synchronous raw button into a single-cycle accept pulse.
// Accept fires combinationally on the DEBOUNCE_CYCLES-th consecutive high sample.
// No backpressure; a held button yields exactly one accept until released.
module button_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state and accept pulse; accept is Mealy so the request latches on the
  // same edge that takes the final qualifying sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      DB_RELEASED: begin
        if (btn) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = DB_HELD;
            accept  = 1'b1;
          end else begin
            state_d = DB_COUNTING;
            cnt_d   = CW'(1);
          end
        end
      end
      DB_COUNTING: begin
        if (!btn) begin
          state_d = DB_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DB_HELD: begin
        if (!btn) begin
          state_d = DB_RELEASED;
        end
      end
      default: begin
        state_d = DB_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/call_register.sv
// Latches debounced hall/car presses as pending requests and clears them on service.
// Request rises on the edge of the last debounce sample; clears on the serving edge.
// No backpressure; service beats a same-cycle press so a served flag ends at 0.
module call_register
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u1,
  input  logic       btn_u2,
  input  logic       btn_d2,
  input  logic       btn_d3,
  input  logic       btn_f1,
  input  logic       btn_f2,
  input  logic       btn_f3,
  input  logic [1:0] FS,
  input  logic       door,
  input  logic [1:0] direction,
  output logic       UP1,
  output logic       UP2,
  output logic       DOWN2,
  output logic       DOWN3,
  output logic       FLOOR1,
  output logic       FLOOR2,
  output logic       FLOOR3,
  output logic       pending
);

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] accept_vec;
  logic [NUM_BTNS-1:0] serve_vec;
  logic [NUM_BTNS-1:0] req_q, req_d;

  assign btn_vec[BTN_U1] = btn_u1;
  assign btn_vec[BTN_U2] = btn_u2;
  assign btn_vec[BTN_D2] = btn_d2;
  assign btn_vec[BTN_D3] = btn_d3;
  assign btn_vec[BTN_F1] = btn_f1;
  assign btn_vec[BTN_F2] = btn_f2;
  assign btn_vec[BTN_F3] = btn_f3;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn_vec[gi]),
      .accept (accept_vec[gi])
    );
  end

  // Set on accept, clear on serve, serve has priority.
  always_comb begin
    serve_vec = serve_mask(FS, door, direction);
    req_d     = (req_q | accept_vec) & ~serve_vec;
  end

  // Request flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign UP1     = req_q[BTN_U1];
  assign UP2     = req_q[BTN_U2];
  assign DOWN2   = req_q[BTN_D2];
  assign DOWN3   = req_q[BTN_D3];
  assign FLOOR1  = req_q[BTN_F1];
  assign FLOOR2  = req_q[BTN_F2];
  assign FLOOR3  = req_q[BTN_F3];
  assign pending = |req_q;

endmodule
